// File: rtl/dense_pkg.sv
// Shared constants, saturation limits and FSM state type for the L1 dense layer.
// Build option: DENSE_RELU_EN (clamp negative results to zero) is consumed by dense_mac.
package dense_pkg;

    localparam int DW     = 20;
    localparam int FRAC   = 16;
    localparam int ACC_W  = 50;
    localparam int PROD_W = 2 * DW;

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Limits widened to accumulator width so the rounded sum compares signed.
    localparam logic signed [ACC_W-1:0] SAT_HI_EXT = {{(ACC_W-DW){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] SAT_LO_EXT = {{(ACC_W-DW){1'b1}}, SAT_MIN};
    localparam logic signed [ACC_W-1:0] RND_HALF   =
        {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_ROUND,
        S_DONE
    } state_e;

endpackage

// File: rtl/dense_mac.sv
// Multiply-accumulate, bias add, round-half-up and saturation for the dense layer.
// DENSE_RELU_EN: when defined, negative saturated results are written as zero.
module dense_mac
    import dense_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          issue_i,
    input  logic          round_i,
    input  logic [DW-1:0] l1_data_i,
    input  logic [DW-1:0] w_data_i,
    input  logic [DW-1:0] bias_i,
    output logic [DW-1:0] result_o,
    output logic          result_valid_o
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  bias_ext, sum, rnd, r_s;
    logic        [DW-1:0]     sat, res_d;
    logic                     data_vld_q;
    logic        [DW-1:0]     result_q;
    logic                     result_valid_q;

    assign prod = $signed(l1_data_i) * $signed(w_data_i);

    always_comb begin
        acc_d    = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        bias_ext = {{(ACC_W-DW-FRAC){bias_i[DW-1]}}, bias_i, {FRAC{1'b0}}};
        sum      = acc_q + bias_ext;
        rnd      = sum + RND_HALF;
        r_s      = rnd >>> FRAC;
        if (r_s > SAT_HI_EXT) begin
            sat = SAT_MAX;
        end else if (r_s < SAT_LO_EXT) begin
            sat = SAT_MIN;
        end else begin
            sat = r_s[DW-1:0];
        end
`ifdef DENSE_RELU_EN
        res_d = sat[DW-1] ? '0 : sat;
`else
        res_d = sat;
`endif
    end

    // Read data lags the issue strobe by one cycle, so accumulation follows issue_i delayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q          <= '0;
            data_vld_q     <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            data_vld_q     <= issue_i;
            result_valid_q <= round_i;
            if (clear_i) begin
                acc_q <= '0;
            end else if (data_vld_q) begin
                acc_q <= acc_d;
            end
            if (round_i) begin
                result_q <= res_d;
            end
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;

endmodule

// File: rtl/l1_dense.sv
// Dense-layer controller: streams N_IN L1/weight pairs into dense_mac, then rounds.
// Build option: DENSE_RELU_EN (see dense_mac).
module l1_dense #(
    parameter int N_IN = 1024,
    parameter int AW   = 10,
    parameter int DW   = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          l1_rd,
    output logic [AW-1:0] l1_addr,
    input  logic [DW-1:0] l1_data,
    output logic          w_rd,
    output logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic [DW-1:0] bias,
    output logic [DW-1:0] result,
    output logic          result_valid
);
    import dense_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_IN - 1);

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          accept;
    logic          round_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = '0;
                    accept  = 1'b1;
                end
            end
            S_FETCH: begin
                // The address freezes on the last issue and stays there until the next run.
                if (addr_q == LAST_ADDR) begin
                    rd_d    = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign round_en = (state_q == S_ROUND);

    dense_mac u_mac (
        .clk            (clk),
        .reset          (reset),
        .clear_i        (accept),
        .issue_i        (rd_q),
        .round_i        (round_en),
        .l1_data_i      (l1_data),
        .w_data_i       (w_data),
        .bias_i         (bias),
        .result_o       (result),
        .result_valid_o (result_valid)
    );

    assign busy    = busy_q;
    assign l1_rd   = rd_q;
    assign w_rd    = rd_q;
    assign l1_addr = addr_q;
    assign w_addr  = addr_q;

endmodule

// File: tb/tb_l1_dense.sv
// Scoreboard bench for l1_dense: registered-read memory models, per-scenario tasks.
module tb_l1_dense;

    localparam int N_IN = 1024;
    localparam int AW   = 10;
    localparam int DW   = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          l1_rd;
    logic [AW-1:0] l1_addr;
    logic [DW-1:0] l1_data;
    logic          w_rd;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] bias;
    logic [DW-1:0] result;
    logic          result_valid;

    logic [DW-1:0] l1_mem [0:N_IN-1];
    logic [DW-1:0] w_mem  [0:N_IN-1];
    logic [DW-1:0] exp_q  [$];

    int n_cmp = 0;
    int n_bad = 0;
    int tick  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick <= tick + 1;
        if (l1_rd) l1_data <= l1_mem[l1_addr];
        if (w_rd)  w_data  <= w_mem[w_addr];
    end

    l1_dense #(.N_IN(N_IN), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .l1_rd        (l1_rd),
        .l1_addr      (l1_addr),
        .l1_data      (l1_data),
        .w_rd         (w_rd),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .bias         (bias),
        .result       (result),
        .result_valid (result_valid)
    );

    function automatic logic [DW-1:0] model();
        longint acc = 0;
        longint s, r;
        logic [DW-1:0] v;
        for (int i = 0; i < N_IN; i++)
            acc += longint'($signed(l1_mem[i])) * longint'($signed(w_mem[i]));
        s = acc + (longint'($signed(bias)) <<< 16);
        r = (s + 64'sd32768) >>> 16;
        if (r > 64'sd524287)       v = 20'h7FFFF;
        else if (r < -64'sd524288) v = 20'h80000;
        else                       v = r[DW-1:0];
`ifdef DENSE_RELU_EN
        if (v[DW-1]) v = '0;
`endif
        return v;
    endfunction

    task automatic fill(input logic [DW-1:0] l1v, input logic [DW-1:0] wv, input logic [DW-1:0] bv);
        for (int i = 0; i < N_IN; i++) begin
            l1_mem[i] = l1v;
            w_mem[i]  = wv;
        end
        bias = bv;
    endtask

    task automatic do_run(input string name, input logic [DW-1:0] expv);
        int cyc = 1;
        int issues = 0;
        bit seen = 0;
        bit lock_err = 0;
        bit addr_err = 0;
        logic [DW-1:0] e = '0;
        exp_q.push_back(expv);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_busy: got %b want 1", name, busy);
        end
        while (!seen && cyc <= N_IN + 20) begin
            if (l1_rd !== w_rd || l1_addr !== w_addr) lock_err = 1;
            if (l1_rd === 1'b1) begin
                if (l1_addr !== AW'(issues)) addr_err = 1;
                issues++;
            end
            if (result_valid === 1'b1) begin
                seen = 1;
                e = exp_q.pop_front();
                n_cmp++;
                if (result !== e) begin
                    n_bad++;
                    $display("FAIL %s_result: got %h want %h", name, result, e);
                end
                n_cmp++;
                if (cyc != N_IN + 3) begin
                    n_bad++;
                    $display("FAIL %s_latency: got %0d want %0d", name, cyc, N_IN + 3);
                end
            end else begin
                cyc++;
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_timeout: got no strobe want strobe by cycle %0d", name, N_IN + 3);
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (issues != N_IN || lock_err || addr_err) begin
            n_bad++;
            $display("FAIL %s_issue: got %0d issues lock_err=%0b addr_err=%0b want %0d 0 0",
                     name, issues, lock_err, addr_err, N_IN);
        end
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== e || l1_addr !== AW'(N_IN - 1)) begin
            n_bad++;
            $display("FAIL %s_after: got rv=%b busy=%b res=%h addr=%0d want 0 0 %h %0d",
                     name, result_valid, busy, result, l1_addr, e, N_IN - 1);
        end
        $display("run %s: result=%h expected=%h latency=%0d", name, result, e, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        fill('0, '0, '0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || l1_rd !== 1'b0 || w_rd !== 1'b0 || result_valid !== 1'b0 ||
            l1_addr !== '0 || w_addr !== '0 || result !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b rd=%b/%b rv=%b addr=%0d/%0d res=%h want all 0",
                     busy, l1_rd, w_rd, result_valid, l1_addr, w_addr, result);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_directed();
        fill('0, '0, 20'h01310);
        do_run("bias_only", 20'h01310);
        fill(20'h10000, 20'h00040, '0);
        do_run("unity", 20'h10000);
        fill(20'h00010, 20'hF0000, '0);
`ifdef DENSE_RELU_EN
        do_run("negative", 20'h00000);
`else
        do_run("negative", 20'hFC000);
`endif
        fill(20'h7FFFF, 20'h7FFFF, '0);
        do_run("sat_pos", 20'h7FFFF);
        fill(20'h7FFFF, 20'h80000, '0);
`ifdef DENSE_RELU_EN
        do_run("sat_neg", 20'h00000);
`else
        do_run("sat_neg", 20'h80000);
`endif
        fill('0, '0, '0);
        l1_mem[0] = 20'h00001;
        w_mem[0]  = 20'h08000;
        do_run("round_half", 20'h00001);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                l1_mem[i] = DW'($urandom);
                w_mem[i]  = DW'($signed($urandom_range(0, 127)) - 64);
            end
            bias = DW'($urandom);
            do_run($sformatf("random%0d", k), model());
        end
    endtask

    task automatic test_abort();
        int cyc = 1;
        bit pulsed = 0;
        bit step_err = 0;
        bit strobe = 0;
        for (int i = 0; i < N_IN; i++) begin
            l1_mem[i] = DW'($urandom);
            w_mem[i]  = DW'($urandom);
        end
        bias = 20'h00100;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (l1_addr !== AW'(500) && cyc < 2000) begin
            if (l1_addr !== AW'(cyc - 1) || result_valid !== 1'b0) step_err = 1;
            if (l1_addr === AW'(200) && !pulsed) begin
                start = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (step_err || cyc != 501) begin
            n_bad++;
            $display("FAIL abort_ignored_start: got step_err=%0b cyc=%0d want 0 501", step_err, cyc);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || l1_rd !== 1'b0 || result_valid !== 1'b0 || l1_addr !== '0) begin
            n_bad++;
            $display("FAIL abort_reset: got busy=%b rd=%b rv=%b addr=%0d want 0 0 0 0",
                     busy, l1_rd, result_valid, l1_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid !== 1'b0 || busy !== 1'b0) strobe = 1;
        end
        n_cmp++;
        if (strobe) begin
            n_bad++;
            $display("FAIL abort_no_strobe: got activity after abort want none");
        end
        $display("abort: reset at address 500 checked");
        do_run("post_abort", model());
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        int t1 = 0;
        int t2 = 0;
        int n = 0;
        fill(20'h00800, 20'h00100, 20'hFF000);
        e = model();
        exp_q.push_back(e);
        exp_q.push_back(e);
        @(negedge clk) start = 1'b1;
        while (result_valid !== 1'b1 && n < N_IN + 20) begin
            @(negedge clk);
            n++;
        end
        t1 = tick;
        n_cmp++;
        if (result_valid !== 1'b1 || result !== exp_q.pop_front()) begin
            n_bad++;
            $display("FAIL b2b_first: got rv=%b res=%h want 1 %h", result_valid, result, e);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle_busy: got %b want 0", busy);
        end
        @(negedge clk) start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_restart: got busy=%b want 1", busy);
        end
        n = 0;
        while (result_valid !== 1'b1 && n < N_IN + 20) begin
            @(negedge clk);
            n++;
        end
        t2 = tick;
        n_cmp++;
        if (result_valid !== 1'b1 || result !== exp_q.pop_front() || t2 - t1 != N_IN + 4) begin
            n_bad++;
            $display("FAIL b2b_second: got rv=%b res=%h gap=%0d want 1 %h %0d",
                     result_valid, result, t2 - t1, e, N_IN + 4);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_stop: got busy=%b want 0", busy);
        end
        $display("back_to_back: result=%h expected=%h gap=%0d", result, e, t2 - t1);
    endtask

    initial begin
        l1_data = '0;
        w_data  = '0;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/l1_dense.md
L1_DENSE -- requirements
Module: l1_dense

Interface
REQ-001 Parameter N_IN, default 1024, number of L1 inputs accumulated per run.
REQ-002 Parameter AW, default 10, address width of the L1 and weight read ports.
REQ-003 Parameter DW, default 20, data width: signed fixed point, 4 integer and 16 fractional bits.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port reset, input, 1; the block SHALL use reset as an asynchronous, active-high reset and clk as its clock.
REQ-006 Port start, input, 1, run request, sampled only in IDLE.
REQ-007 Port busy, output, 1, high from the cycle after start is accepted until DONE is left.
REQ-008 Port l1_rd, output, 1, L1 memory read enable.
REQ-009 Port l1_addr, output, AW, L1 read address.
REQ-010 Port l1_data, input, DW, signed L1 word, valid the cycle after l1_rd.
REQ-011 Port w_rd, output, 1, weight memory read enable.
REQ-012 Port w_addr, output, AW, weight read address.
REQ-013 Port w_data, input, DW, signed weight, valid the cycle after w_rd.
REQ-014 Port bias, input, DW, signed bias, held stable while busy.
REQ-015 Port result, output, DW, signed dense output.
REQ-016 Port result_valid, output, 1, one-cycle strobe qualifying result.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN, ROUND and DONE.
REQ-018 Transitions SHALL be:
- IDLE to FETCH on start.
- FETCH to DRAIN after N_IN issue cycles.
- DRAIN to ROUND after one cycle.
- ROUND to DONE after one cycle.
- DONE to IDLE after one cycle.
REQ-019 In FETCH, l1_rd and w_rd SHALL be high for exactly N_IN consecutive cycles; l1_addr and w_addr SHALL step 0 to N_IN-1, one per cycle, identical each cycle.
REQ-020 Outside FETCH, l1_rd and w_rd SHALL be low and addresses SHALL hold their last value.
REQ-021 Each cycle after an issue cycle, acc SHALL accumulate l1_data*w_data; the full 40-bit signed product is added into a 50-bit signed accumulator, so no overflow is possible for N_IN ≤ 1024.
REQ-022 The accumulator SHALL clear on the start-accept edge.
REQ-023 ROUND SHALL compute s = acc + (sign-extended bias << 16), then r = (s + 2^15) >>> 16 (arithmetic shift, round half up).
REQ-024 r SHALL saturate to [0x80000, 0x7FFFF] and be registered into result.
REQ-025 result_valid SHALL be high exactly one cycle, the third cycle after the last FETCH cycle (N_IN+3 cycles after the start-accept edge).
REQ-026 result SHALL hold its value until the next run's strobe.
REQ-027 start SHALL be ignored while busy; start held high in IDLE SHALL begin a new run each time IDLE is re-entered.
REQ-028 busy SHALL fall on the edge leaving DONE.

Reset
REQ-029 Reset SHALL force:
- state IDLE and accumulator 0.
- busy, l1_rd, w_rd and result_valid to 0.
- l1_addr, w_addr and result to 0.
REQ-030 Reset mid-run SHALL abort with no result_valid; the next start SHALL run normally from address 0.

Configuration
REQ-031 With DENSE_RELU_EN defined, a saturated negative r SHALL be written as 0 in result.
REQ-032 Without DENSE_RELU_EN, signed saturated r SHALL pass unchanged.

Structure
REQ-033 Package dense_pkg SHALL hold:
- DW, the FRAC=16 constant and ACC_W=50.
- Saturation limits.
- The state enum type.
REQ-034 Sub-module dense_mac SHALL hold the multiply, accumulator, round and saturate; l1_dense holds the FSM and address counter.

Verification
REQ-035 All weights 0, bias 0x01310 -> result 0x01310, result_valid at cycle N_IN+3.
REQ-036 All L1 = 0x10000, all weights = 0x00040, bias 0 -> result 0x10000.
REQ-037 All L1 = 0x00010, all weights = 0xF0000, bias 0 -> 0xFC000 without DENSE_RELU_EN, 0x00000 with it.
REQ-038 All L1 and all weights 0x7FFFF -> result saturates to 0x7FFFF.
REQ-039 N_IN=4, L1[0]=0x00001, w[0]=0x08000, others 0 -> result 0x00001 (round half up).
REQ-040 Reset asserted at address 500; start pulsed while busy -> abort with no strobe; the ignored start has no effect; the following run matches the reference model.
